// File: rtl/byte_window_shifter_pkg.sv
// Shared types and defaults for the LZ4 byte realignment window.
// Holds FSM states, default geometry and a small min() helper.
package lz4_shift_pkg;

  localparam int unsigned IN_BYTES_DEF    = 4;
  localparam int unsigned OUT_BYTES_DEF   = 4;
  localparam int unsigned DEPTH_BYTES_DEF = 12;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int unsigned min(
    input int unsigned a,
    input int unsigned b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_window_shifter_if.sv
// Handshake/bus bundle of byte_window_shifter.
// master: source+consumer side; slave: the window itself.
interface byte_window_shifter_if
  import lz4_shift_pkg::*;
#(
  parameter int unsigned IN_BYTES    = IN_BYTES_DEF,
  parameter int unsigned OUT_BYTES   = OUT_BYTES_DEF,
  parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int unsigned LVL_W = $clog2(DEPTH_BYTES+1),
  parameter int unsigned SH_W  = $clog2(OUT_BYTES+1)
);
  localparam int unsigned NB_W = $clog2(IN_BYTES+1);

  logic [IN_BYTES*8-1:0]  in_data;
  logic                   in_valid;
  logic [NB_W-1:0]        in_bytes;
  logic                   in_last;
  logic                   in_ready;
  logic                   shift_valid;
  logic [SH_W-1:0]        in_shift;
  logic [OUT_BYTES*8-1:0] out_data;
  logic [SH_W-1:0]        out_mask;
  logic                   out_empty;
  logic                   out_last;
  logic [LVL_W-1:0]       level;
  logic                   shift_err;
  logic                   done;

  modport master (
    output in_data, in_valid, in_bytes, in_last,
    output shift_valid, in_shift,
    input  in_ready, out_data, out_mask, out_empty,
    input  out_last, level, shift_err, done
  );

  modport slave (
    input  in_data, in_valid, in_bytes, in_last,
    input  shift_valid, in_shift,
    output in_ready, out_data, out_mask, out_empty,
    output out_last, level, shift_err, done
  );

endinterface

// File: rtl/byte_window_shifter_glue.sv
// byte_glue: combinational shift-left-then-insert of a byte window.
// Ports: win_i, sh_i (bytes), pos_i (insert byte), word_i, nb_i -> win_o.
module byte_glue #(
  parameter int unsigned DEPTH_BYTES = 12,
  parameter int unsigned IN_BYTES    = 4,
  parameter int unsigned SH_W        = 3,
  parameter int unsigned POS_W       = 4,
  parameter int unsigned NB_W        = 3
) (
  input  logic [DEPTH_BYTES*8-1:0] win_i,
  input  logic [SH_W-1:0]          sh_i,
  input  logic [POS_W-1:0]         pos_i,
  input  logic [IN_BYTES*8-1:0]    word_i,
  input  logic [NB_W-1:0]          nb_i,
  output logic [DEPTH_BYTES*8-1:0] win_o
);
  localparam int unsigned DW = DEPTH_BYTES*8;
  localparam int unsigned IW = IN_BYTES*8;

  logic [IW-1:0] word_m;
  logic [DW-1:0] ins;

  always_comb begin
    word_m = '0;
    for (int i = 0; i < int'(IN_BYTES); i++) begin
      if (i < int'(nb_i))
        word_m[IW-1-8*i -: 8] = word_i[IW-1-8*i -: 8];
    end
    // word sits at the MSB end, then slides to pos_i
    ins   = {word_m, {(DW-IW){1'b0}}} >> {pos_i, 3'b000};
    win_o = (win_i << {sh_i, 3'b000}) | ins;
  end

endmodule

// File: rtl/byte_window_shifter.sv
// Byte realignment window: loads words behind valid bytes, retires 0..OUT.
// Ports: clk, rstN, bus (slave); bytes_in/out with BYTE_WINDOW_STATS_EN.
module byte_window_shifter
  import lz4_shift_pkg::*;
#(
  parameter int unsigned IN_BYTES    = IN_BYTES_DEF,
  parameter int unsigned OUT_BYTES   = OUT_BYTES_DEF,
  parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int unsigned LVL_W = $clog2(DEPTH_BYTES+1),
  parameter int unsigned SH_W  = $clog2(OUT_BYTES+1)
) (
  input  logic clk,
  input  logic rstN,
  byte_window_shifter_if.slave bus
`ifdef BYTE_WINDOW_STATS_EN
  ,
  output logic [31:0] bytes_in,
  output logic [31:0] bytes_out
`endif
);
  localparam int unsigned DW   = DEPTH_BYTES*8;
  localparam int unsigned NB_W = $clog2(IN_BYTES+1);

  logic [DW-1:0]    win_q, win_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  mask;
  logic [SH_W-1:0]  eff;
  logic [NB_W-1:0]  nb;
  logic [LVL_W-1:0] pos;
  logic             rdy;
  logic             load;

  assign rdy = (state_q == ST_RUN) &&
    (level_q <= LVL_W'(DEPTH_BYTES-IN_BYTES));

  always_comb begin
    mask = SH_W'(min(32'(level_q), OUT_BYTES));
    load = bus.in_valid && rdy;
    nb   = '0;
    if (load)
      nb = bus.in_last
        ? NB_W'(min(32'(bus.in_bytes), IN_BYTES))
        : NB_W'(IN_BYTES);
    eff = '0;
    if (bus.shift_valid)
      eff = SH_W'(min(32'(bus.in_shift), 32'(mask)));
    err_d = err_q |
      (bus.shift_valid && (bus.in_shift > mask));
    pos     = level_q - LVL_W'(eff);
    level_d = pos + LVL_W'(nb);
  end

  byte_glue #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IN_BYTES    (IN_BYTES),
    .SH_W        (SH_W),
    .POS_W       (LVL_W),
    .NB_W        (NB_W)
  ) u_glue (
    .win_i  (win_q),
    .sh_i   (eff),
    .pos_i  (pos),
    .word_i (bus.in_data),
    .nb_i   (nb),
    .win_o  (win_d)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (load && bus.in_last)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (level_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      win_q   <= '0;
      level_q <= '0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      level_q <= level_d;
      state_q <= state_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = win_q[DW-1 -: OUT_BYTES*8];
  assign bus.out_mask  = mask;
  assign bus.out_empty = (level_q == '0);
  assign bus.out_last  = (state_q == ST_DRAIN) &&
    (level_q <= LVL_W'(OUT_BYTES));
  assign bus.level     = level_q;
  assign bus.shift_err = err_q;
  assign bus.done      = done_q;

`ifdef BYTE_WINDOW_STATS_EN
  logic [31:0] bin_q, bin_d;
  logic [31:0] bout_q, bout_d;

  always_comb begin
    bin_d  = bin_q + 32'(nb);
    bout_d = bout_q + 32'(eff);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bin_q  <= '0;
      bout_q <= '0;
    end else begin
      bin_q  <= bin_d;
      bout_q <= bout_d;
    end
  end

  assign bytes_in  = bin_q;
  assign bytes_out = bout_q;
`endif

endmodule

// File: tb/tb_byte_window_shifter.sv
// Self-checking bench for byte_window_shifter (4/4/12 geometry).
// Directed scenarios plus random streams against a byte-queue model.
module tb_byte_window_shifter;

  localparam int IB = 4;
  localparam int OB = 4;
  localparam int DB = 12;

  logic clk;
  logic rstN;
  int   checks;
  int   errs;

  byte_window_shifter_if #(
    .IN_BYTES(IB), .OUT_BYTES(OB), .DEPTH_BYTES(DB)
  ) bus ();

`ifdef BYTE_WINDOW_STATS_EN
  logic [31:0] bytes_in;
  logic [31:0] bytes_out;
  byte_window_shifter #(
    .IN_BYTES(IB), .OUT_BYTES(OB), .DEPTH_BYTES(DB)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .bus       (bus),
    .bytes_in  (bytes_in),
    .bytes_out (bytes_out)
  );
`else
  byte_window_shifter #(
    .IN_BYTES(IB), .OUT_BYTES(OB), .DEPTH_BYTES(DB)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: window as a queue of bytes, front = earliest
  byte unsigned mq[$];
  int           mst;
  bit           merr;
  bit           mdone;
  int unsigned  m_in;
  int unsigned  m_out;

  function automatic int tmin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] m_top();
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < OB; i++)
      if (i < mq.size()) e[31-8*i -: 8] = mq[i];
    return e;
  endfunction

  task automatic m_clear();
    mq.delete();
    mst = 0; merr = 0; mdone = 0;
    m_in = 0; m_out = 0;
  endtask

  task automatic m_step(
    input bit v, input logic [31:0] d, input int nbv,
    input bit last, input bit sv, input int sh
  );
    int  mask, eff, nb, prev;
    bit  ld;
    prev  = mst;
    mask  = tmin(mq.size(), OB);
    ld    = v && mst == 0 && mq.size() <= DB - IB;
    eff   = sv ? tmin(sh, mask) : 0;
    if (sv && sh > mask) merr = 1;
    for (int i = 0; i < eff; i++) void'(mq.pop_front());
    nb = 0;
    if (ld) begin
      nb = last ? tmin(nbv, IB) : IB;
      for (int i = 0; i < nb; i++)
        mq.push_back(d[31-8*i -: 8]);
    end
    m_in  += nb;
    m_out += eff;
    mdone = 0;
    if (prev == 0 && ld && last) mst = 1;
    else if (prev == 1 && mq.size() == 0) begin
      mst = 2; mdone = 1;
    end
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_bytes    = '0;
    bus.in_last     = 1'b0;
    bus.shift_valid = 1'b0;
    bus.in_shift    = '0;
  endtask

  task automatic cyc(
    input bit v, input logic [31:0] d, input int nbv,
    input bit last, input bit sv, input int sh
  );
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_bytes    = 3'(nbv);
    bus.in_last     = last;
    bus.shift_valid = sv;
    bus.in_shift    = 3'(sh);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    m_clear();
  endtask

  task automatic test_reset();
    idle();
    rstN = 1'b0;
    #12;
    checks++;
    if (bus.level !== 4'd0 || bus.out_mask !== 3'd0) begin
      errs++;
      $display("FAIL reset_lvl got=%0d/%0d want=0/0",
        bus.level, bus.out_mask);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_empty !== 1'b1) begin
      errs++;
      $display("FAIL reset_rdy got=%b%b want=11",
        bus.in_ready, bus.out_empty);
    end
    checks++;
    if ({bus.out_last, bus.shift_err, bus.done} !== 3'b000 ||
        bus.out_data !== 32'h0) begin
      errs++;
      $display("FAIL reset_flags got=%b%b%b %h want=000 0",
        bus.out_last, bus.shift_err, bus.done, bus.out_data);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.level !== 4'd0) begin
      errs++;
      $display("FAIL reset_rel got=%b/%0d want=1/0",
        bus.in_ready, bus.level);
    end
  endtask

  task automatic test_fill();
    do_reset();
    cyc(1, 32'h11223344, 4, 0, 0, 0);
    cyc(1, 32'h55667788, 4, 0, 0, 0);
    checks++;
    if (bus.level !== 4'd8 || bus.out_data !== 32'h11223344 ||
        bus.out_mask !== 3'd4 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL fill8 got=%0d %h %0d %b want=8 11223344 4 1",
        bus.level, bus.out_data, bus.out_mask, bus.in_ready);
    end
    cyc(1, 32'h99AABBCC, 4, 0, 0, 0);
    checks++;
    if (bus.level !== 4'd12 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL fill12 got=%0d %b want=12 0",
        bus.level, bus.in_ready);
    end
    cyc(1, 32'hDEADBEEF, 4, 0, 0, 0);
    checks++;
    if (bus.level !== 4'd12 || bus.out_data !== 32'h11223344) begin
      errs++;
      $display("FAIL fill_hold got=%0d %h want=12 11223344",
        bus.level, bus.out_data);
    end
  endtask

  task automatic test_load_shift();
    do_reset();
    cyc(1, 32'h11223344, 4, 0, 0, 0);
    cyc(1, 32'h55667788, 4, 0, 0, 0);
    cyc(1, 32'hAABBCCDD, 4, 0, 1, 3);
    checks++;
    if (bus.level !== 4'd9 || bus.out_data !== 32'h44556677) begin
      errs++;
      $display("FAIL ldsh got=%0d %h want=9 44556677",
        bus.level, bus.out_data);
    end
    cyc(0, 0, 0, 0, 1, 4);
    checks++;
    if (bus.level !== 4'd5 || bus.out_data !== 32'h88AABBCC) begin
      errs++;
      $display("FAIL ldsh2 got=%0d %h want=5 88AABBCC",
        bus.level, bus.out_data);
    end
    cyc(0, 0, 0, 0, 1, 4);
    checks++;
    if (bus.level !== 4'd1 || bus.out_data !== 32'hDD000000 ||
        bus.out_mask !== 3'd1 || bus.shift_err !== 1'b0) begin
      errs++;
      $display("FAIL ldsh3 got=%0d %h %0d %b want=1 DD000000 1 0",
        bus.level, bus.out_data, bus.out_mask, bus.shift_err);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    cyc(1, 32'h11223344, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2);
    checks++;
    if (bus.level !== 4'd2 || bus.out_data !== 32'h33440000 ||
        bus.shift_err !== 1'b0) begin
      errs++;
      $display("FAIL ovr_pre got=%0d %h %b want=2 33440000 0",
        bus.level, bus.out_data, bus.shift_err);
    end
    cyc(0, 0, 0, 0, 1, 4);
    checks++;
    if (bus.level !== 4'd0 || bus.out_empty !== 1'b1 ||
        bus.shift_err !== 1'b1) begin
      errs++;
      $display("FAIL ovr got=%0d %b %b want=0 1 1",
        bus.level, bus.out_empty, bus.shift_err);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h55667788, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    checks++;
    if (bus.shift_err !== 1'b1 || bus.level !== 4'd3 ||
        bus.out_data !== 32'h66778800) begin
      errs++;
      $display("FAIL ovr_sticky got=%b %0d %h want=1 3 66778800",
        bus.shift_err, bus.level, bus.out_data);
    end
  endtask

  task automatic test_last();
    do_reset();
    cyc(1, 32'h01020304, 2, 1, 0, 0);
    checks++;
    if (bus.level !== 4'd2 || bus.out_data !== 32'h01020000 ||
        bus.out_last !== 1'b1 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL last got=%0d %h %b %b want=2 01020000 1 0",
        bus.level, bus.out_data, bus.out_last, bus.in_ready);
    end
    cyc(0, 0, 0, 0, 1, 2);
    checks++;
    if (bus.done !== 1'b1 || bus.level !== 4'd0 ||
        bus.out_empty !== 1'b1 || bus.out_last !== 1'b0) begin
      errs++;
      $display("FAIL drain got=%b %0d %b %b want=1 0 1 0",
        bus.done, bus.level, bus.out_empty, bus.out_last);
    end
    cyc(1, 32'hCAFEF00D, 4, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.level !== 4'd0) begin
      errs++;
      $display("FAIL done_hold got=%b %b %0d want=0 0 0",
        bus.done, bus.in_ready, bus.level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 32'h10203040, 4, 0, 0, 0);
    cyc(1, 32'hA1B2C3D4, 1, 1, 0, 0);
    checks++;
    if (bus.level !== 4'd5 || bus.out_last !== 1'b0 ||
        bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL mid_pre got=%0d %b %b want=5 0 0",
        bus.level, bus.out_last, bus.in_ready);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (bus.level !== 4'd0 || bus.out_data !== 32'h0 ||
        bus.out_mask !== 3'd0 || bus.out_empty !== 1'b1) begin
      errs++;
      $display("FAIL mid_rst got=%0d %h %0d %b want=0 0 0 1",
        bus.level, bus.out_data, bus.out_mask, bus.out_empty);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_last !== 1'b0) begin
      errs++;
      $display("FAIL mid_rel got=%b %b want=1 0",
        bus.in_ready, bus.out_last);
    end
    m_clear();
  endtask

  task automatic test_random();
    bit          v, last, sv;
    logic [31:0] d;
    int          nbv, sh;
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 200 && mst != 2; c++) begin
        v    = ($urandom % 4) != 0;
        d    = $urandom;
        last = ($urandom % 16) == 0;
        nbv  = $urandom_range(0, 4);
        sv   = ($urandom % 2) != 0;
        sh   = (($urandom % 8) == 0) ?
          $urandom_range(5, 7) : $urandom_range(0, 4);
        m_step(v, d, nbv, last, sv, sh);
        cyc(v, d, nbv, last, sv, sh);
        checks++;
        if (bus.out_data !== m_top()) begin
          errs++;
          $display("FAIL rnd_data s=%0d c=%0d got=%h want=%h",
            s, c, bus.out_data, m_top());
        end
        checks++;
        if (bus.level !== 4'(mq.size())) begin
          errs++;
          $display("FAIL rnd_lvl s=%0d c=%0d got=%0d want=%0d",
            s, c, bus.level, mq.size());
        end
        checks++;
        if (bus.out_mask !== 3'(tmin(mq.size(), OB))) begin
          errs++;
          $display("FAIL rnd_mask s=%0d c=%0d got=%0d",
            s, c, bus.out_mask);
        end
        checks++;
        if (bus.in_ready !== (mst == 0 && mq.size() <= DB - IB)) begin
          errs++;
          $display("FAIL rnd_rdy s=%0d c=%0d got=%b",
            s, c, bus.in_ready);
        end
        checks++;
        if (bus.out_last !== (mst == 1 && mq.size() <= OB) ||
            bus.out_empty !== (mq.size() == 0)) begin
          errs++;
          $display("FAIL rnd_flags s=%0d c=%0d got=%b%b",
            s, c, bus.out_last, bus.out_empty);
        end
        checks++;
        if (bus.shift_err !== merr || bus.done !== mdone) begin
          errs++;
          $display("FAIL rnd_err s=%0d c=%0d got=%b%b want=%b%b",
            s, c, bus.shift_err, bus.done, merr, mdone);
        end
`ifdef BYTE_WINDOW_STATS_EN
        checks++;
        if (bytes_in !== m_in || bytes_out !== m_out) begin
          errs++;
          $display("FAIL rnd_stats got=%0d/%0d want=%0d/%0d",
            bytes_in, bytes_out, m_in, m_out);
        end
`endif
      end
    end
  endtask

`ifdef BYTE_WINDOW_STATS_EN
  task automatic test_stats();
    do_reset();
    cyc(1, 32'h01020304, 4, 0, 0, 0);
    cyc(1, 32'h05060708, 4, 0, 1, 4);
    cyc(1, 32'h090A0B0C, 4, 0, 1, 4);
    cyc(1, 32'h0D0E0F10, 1, 1, 1, 4);
    cyc(0, 0, 0, 0, 1, 1);
    checks++;
    if (bytes_in !== 32'd13 || bytes_out !== 32'd13 ||
        bus.done !== 1'b1) begin
      errs++;
      $display("FAIL stats got=%0d %0d %b want=13 13 1",
        bytes_in, bytes_out, bus.done);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errs   = 0;
    m_clear();
    idle();
    rstN = 1'b1;
    #1;
    test_reset();
    test_fill();
    test_load_shift();
    test_overrun();
    test_last();
    test_reset_mid();
    test_random();
`ifdef BYTE_WINDOW_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
